b3_countdown: RTL and testbench

//  Loadable N-digit base-3 down-counter/timer. It is the decrement counterpart of
//  the base-3 up-counter digit chain: a borrow propagates LSD->MSD instead of a carry.

---
 rtl/b3_pkg.sv | 21 ++
 rtl/b3_halfsubtractor.sv | 28 ++
 rtl/b3_countdown.sv | 107 ++++++++++
 tb/tb_b3_countdown.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/b3_pkg.sv
// Shared definitions for the base-3 counter family.
// Includes digit codes, FSM state encoding and the digit sanitiser.
package b3_pkg;

  localparam logic [1:0] B3_ZERO = 2'b00;
  localparam logic [1:0] B3_ONE  = 2'b01;
  localparam logic [1:0] B3_TWO  = 2'b10;
  localparam logic [1:0] B3_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } b3_state_e;

  // The illegal code is loaded as zero so q never carries 11.
  function automatic logic [1:0] b3_sanitize(input logic [1:0] digit);
    return (digit == B3_ILL) ? B3_ZERO : digit;
  endfunction

endpackage

// File: rtl/b3_halfsubtractor.sv
// One base-3 digit of the borrow chain.
// With bin=1 the digit decrements; 0 wraps to 2 and raises bout.
module b3_halfsubtractor
  import b3_pkg::*;
(
  input  logic [1:0] x1_x0,
  input  logic       bin,
  output logic [1:0] d1_d0,
  output logic       bout
);

  always_comb begin
    d1_d0 = x1_x0;
    bout  = 1'b0;
    if (bin) begin
      case (x1_x0)
        B3_ZERO: begin
          d1_d0 = B3_TWO;
          bout  = 1'b1;
        end
        B3_ONE:  d1_d0 = B3_ZERO;
        B3_TWO:  d1_d0 = B3_ONE;
        default: d1_d0 = B3_ZERO;
      endcase
    end
  end

endmodule

// File: rtl/b3_countdown.sv
// Loadable N-digit base-3 down-counter with IDLE/RUN/DONE control.
// WRAP=0 stops at zero with done; WRAP=1 wraps to all-2s and pulses eu.
module b3_countdown
  import b3_pkg::*;
#(
  parameter int N    = 3,
  parameter int WRAP = 0
) (
  input  logic           clock,
  input  logic           reset_,
  input  logic           load,
  input  logic [2*N-1:0] d_in,
  input  logic           start,
  input  logic           ei,
  output logic [2*N-1:0] q,
  output logic           eu,
  output logic           busy,
  output logic           done,
  output b3_state_e      dbg_state
);

  localparam bit WRAP_EN = (WRAP != 0);
  localparam logic [2*N-1:0] ONE_VAL = {{(2*N-2){1'b0}}, B3_ONE};

  b3_state_e      state_q, state_d;
  logic [2*N-1:0] q_q, q_d;
  logic           eu_q, eu_d;
  logic           busy_q, done_q;

  logic [N:0]     borrow;
  logic [2*N-1:0] q_dec;
  logic [2*N-1:0] q_load;
  logic           q_is_zero;
  logic           q_is_one;

  // Control is level-sampled, no handshake: load wins over start and ei,
  // start is only seen in IDLE, each cycle ei is high in RUN is one decrement.
  assign borrow[0] = ei & (state_q == ST_RUN);

  for (genvar gi = 0; gi < N; gi++) begin : g_digit
    b3_halfsubtractor u_hs (
      .x1_x0 (q_q[2*gi +: 2]),
      .bin   (borrow[gi]),
      .d1_d0 (q_dec[2*gi +: 2]),
      .bout  (borrow[gi+1])
    );
    assign q_load[2*gi +: 2] = b3_sanitize(d_in[2*gi +: 2]);
  end

  assign q_is_zero = (q_q == '0);
  assign q_is_one  = (q_q == ONE_VAL);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    eu_d    = 1'b0;
    if (load) begin
      q_d     = q_load;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = (q_is_zero && !WRAP_EN) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (ei) begin
            // A stopping counter never decrements through zero.
            if (!WRAP_EN && q_is_zero) begin
              state_d = ST_DONE;
            end else begin
              q_d = q_dec;
              if (!WRAP_EN && q_is_one) state_d = ST_DONE;
              if (WRAP_EN && borrow[N]) eu_d = 1'b1;
            end
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      eu_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      eu_q    <= eu_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign q         = q_q;
  assign eu        = eu_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_b3_countdown.sv
// Bench for b3_countdown: WRAP=0 and WRAP=1 instances share stimulus,
// the driver queues hand-computed results and a monitor checks each cycle.
module tb_b3_countdown;
  import b3_pkg::*;

  logic       clock;
  logic       reset_;
  logic       load;
  logic [5:0] d_in;
  logic       start;
  logic       ei;

  logic [5:0] q0, q1;
  logic       eu0, eu1, busy0, busy1, done0, done1;
  b3_state_e  st0, st1;

  int n_vec;
  int n_err;

  // Each entry: {dut1 {q,eu,busy,done}, dut0 {q,eu,busy,done}}
  logic [17:0] exp_q[$];

  b3_countdown #(.N(3), .WRAP(0)) dut0 (
    .clock(clock), .reset_(reset_), .load(load), .d_in(d_in), .start(start), .ei(ei),
    .q(q0), .eu(eu0), .busy(busy0), .done(done0), .dbg_state(st0)
  );

  b3_countdown #(.N(3), .WRAP(1)) dut1 (
    .clock(clock), .reset_(reset_), .load(load), .d_in(d_in), .start(start), .ei(ei),
    .q(q1), .eu(eu1), .busy(busy1), .done(done1), .dbg_state(st1)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    reset_ = 1'b0;
    load   = 1'b0;
    d_in   = '0;
    start  = 1'b0;
    ei     = 1'b0;
  end

  function automatic logic [8:0] pk(input logic [5:0] qv, input logic euv,
                                    input logic bv, input logic dv);
    return {qv, euv, bv, dv};
  endfunction

  // Driver: apply one cycle of inputs and queue both expected results
  task automatic step(input logic rst_n, input logic ld, input logic [5:0] d,
                      input logic st, input logic e,
                      input logic [8:0] x0, input logic [8:0] x1);
    @(negedge clock);
    reset_ = rst_n;
    load   = ld;
    d_in   = d;
    start  = st;
    ei     = e;
    exp_q.push_back({x1, x0});
  endtask

  // Monitor / scoreboard
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [17:0] e;
      logic [8:0]  a0, a1;
      e  = exp_q.pop_front();
      a0 = {q0, eu0, busy0, done0};
      a1 = {q1, eu1, busy1, done1};
      n_vec++;
      if (a0 !== e[8:0]) begin
        n_err++;
        $display("FAIL wrap0 vec %0d: got q=%b eu=%b busy=%b done=%b, required q=%b eu=%b busy=%b done=%b",
                 n_vec, a0[8:3], a0[2], a0[1], a0[0], e[8:3], e[2], e[1], e[0]);
      end
      n_vec++;
      if (a1 !== e[17:9]) begin
        n_err++;
        $display("FAIL wrap1 vec %0d: got q=%b eu=%b busy=%b done=%b, required q=%b eu=%b busy=%b done=%b",
                 n_vec, a1[8:3], a1[2], a1[1], a1[0], e[17:12], e[11], e[10], e[9]);
      end
    end
  end

  logic [5:0] cd [11];

  initial begin
    logic [8:0] idle0;
    n_vec = 0;
    n_err = 0;
    idle0 = pk(6'b00_00_00, 1'b0, 1'b0, 1'b0);
    cd[0] = 6'b01_00_01; cd[1] = 6'b01_00_00; cd[2]  = 6'b00_10_10;
    cd[3] = 6'b00_10_01; cd[4] = 6'b00_10_00; cd[5]  = 6'b00_01_10;
    cd[6] = 6'b00_01_01; cd[7] = 6'b00_01_00; cd[8]  = 6'b00_00_10;
    cd[9] = 6'b00_00_01; cd[10] = 6'b00_00_00;

    // Reset
    step(1'b0, 1'b0, 6'b11_11_11, 1'b1, 1'b1, idle0, idle0);

    // Full countdown from 11, random hold gaps with start asserted (ignored in RUN)
    step(1'b1, 1'b1, 6'b01_00_10, 1'b0, 1'b0, pk(6'b01_00_10, 0, 0, 0), pk(6'b01_00_10, 0, 0, 0));
    step(1'b1, 1'b0, 6'b00_00_00, 1'b1, 1'b0, pk(6'b01_00_10, 0, 1, 0), pk(6'b01_00_10, 0, 1, 0));
    for (int k = 0; k < 11; k++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        logic [5:0] hv;
        hv = (k == 0) ? 6'b01_00_10 : cd[k-1];
        step(1'b1, 1'b0, 6'b00_00_00, 1'b1, 1'b0, pk(hv, 0, 1, 0), pk(hv, 0, 1, 0));
      end
      if (k == 10)
        step(1'b1, 1'b0, 6'b00_00_00, 1'b0, 1'b1, pk(cd[k], 0, 0, 1), pk(cd[k], 0, 1, 0));
      else
        step(1'b1, 1'b0, 6'b00_00_00, 1'b0, 1'b1, pk(cd[k], 0, 1, 0), pk(cd[k], 0, 1, 0));
    end
    // DONE holds; the wrapping counter rolls over with a one-cycle eu
    step(1'b1, 1'b0, 6'b00_00_00, 1'b1, 1'b1, pk(6'b00_00_00, 0, 0, 1), pk(6'b10_10_10, 1, 1, 0));
    step(1'b1, 1'b0, 6'b00_00_00, 1'b1, 1'b0, pk(6'b00_00_00, 0, 0, 1), pk(6'b10_10_10, 0, 1, 0));

    // Borrow chain: 9 -> 8, 18 -> 17
    step(1'b1, 1'b1, 6'b01_00_00, 1'b0, 1'b0, pk(6'b01_00_00, 0, 0, 0), pk(6'b01_00_00, 0, 0, 0));
    step(1'b1, 1'b0, 6'b00_00_00, 1'b1, 1'b0, pk(6'b01_00_00, 0, 1, 0), pk(6'b01_00_00, 0, 1, 0));
    step(1'b1, 1'b0, 6'b00_00_00, 1'b0, 1'b1, pk(6'b00_10_10, 0, 1, 0), pk(6'b00_10_10, 0, 1, 0));
    step(1'b1, 1'b1, 6'b10_00_00, 1'b0, 1'b1, pk(6'b10_00_00, 0, 0, 0), pk(6'b10_00_00, 0, 0, 0));
    step(1'b1, 1'b0, 6'b00_00_00, 1'b1, 1'b0, pk(6'b10_00_00, 0, 1, 0), pk(6'b10_00_00, 0, 1, 0));
    step(1'b1, 1'b0, 6'b00_00_00, 1'b0, 1'b1, pk(6'b01_10_10, 0, 1, 0), pk(6'b01_10_10, 0, 1, 0));

    // Wrap from 1: 1 -> 0 -> 222
    step(1'b1, 1'b1, 6'b00_00_01, 1'b0, 1'b0, pk(6'b00_00_01, 0, 0, 0), pk(6'b00_00_01, 0, 0, 0));
    step(1'b1, 1'b0, 6'b00_00_00, 1'b1, 1'b0, pk(6'b00_00_01, 0, 1, 0), pk(6'b00_00_01, 0, 1, 0));
    step(1'b1, 1'b0, 6'b00_00_00, 1'b0, 1'b1, pk(6'b00_00_00, 0, 0, 1), pk(6'b00_00_00, 0, 1, 0));
    step(1'b1, 1'b0, 6'b00_00_00, 1'b0, 1'b1, pk(6'b00_00_00, 0, 0, 1), pk(6'b10_10_10, 1, 1, 0));
    step(1'b1, 1'b0, 6'b00_00_00, 1'b0, 1'b0, pk(6'b00_00_00, 0, 0, 1), pk(6'b10_10_10, 0, 1, 0));
    step(1'b1, 1'b0, 6'b00_00_00, 1'b0, 1'b1, pk(6'b00_00_00, 0, 0, 1), pk(6'b10_10_01, 0, 1, 0));

    // Load zero then start
    step(1'b1, 1'b1, 6'b00_00_00, 1'b0, 1'b0, idle0, idle0);
    step(1'b1, 1'b0, 6'b00_00_00, 1'b1, 1'b0, pk(6'b00_00_00, 0, 0, 1), pk(6'b00_00_00, 0, 1, 0));
    step(1'b1, 1'b0, 6'b00_00_00, 1'b0, 1'b0, pk(6'b00_00_00, 0, 0, 1), pk(6'b00_00_00, 0, 1, 0));

    // Illegal digits are sanitised on load
    step(1'b1, 1'b1, 6'b11_01_11, 1'b0, 1'b0, pk(6'b00_01_00, 0, 0, 0), pk(6'b00_01_00, 0, 0, 0));

    // Load and start together: start ignored, ei ignored in IDLE
    step(1'b1, 1'b1, 6'b00_10_00, 1'b1, 1'b0, pk(6'b00_10_00, 0, 0, 0), pk(6'b00_10_00, 0, 0, 0));
    step(1'b1, 1'b0, 6'b00_00_00, 1'b0, 1'b1, pk(6'b00_10_00, 0, 0, 0), pk(6'b00_10_00, 0, 0, 0));

    // Reset mid-RUN with ei high: no decrement, back to IDLE
    step(1'b1, 1'b0, 6'b00_00_00, 1'b1, 1'b0, pk(6'b00_10_00, 0, 1, 0), pk(6'b00_10_00, 0, 1, 0));
    step(1'b0, 1'b0, 6'b00_00_00, 1'b0, 1'b1, idle0, idle0);
    step(1'b1, 1'b0, 6'b00_00_00, 1'b0, 1'b1, idle0, idle0);

    @(negedge clock);
    ei = 1'b0;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clock);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
